// File: rtl/par_cmd_ctrl.sv
// Parameter-bus command sequencer: preloads every slot with DEF_VAL after reset,
// then turns validated 4-byte frames (SYNC, A, V, A+V) into single-cycle writes.
module par_cmd_ctrl #(
  parameter int unsigned PAR_MAX_VAL = 255,
  parameter int unsigned ADDR_MAX    = 4,
  parameter int unsigned DEF_VAL     = 250,
  parameter logic [7:0]  SYNC        = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [7:0]                           rx_data,
  input  logic                                 rx_valid,
  output logic                                 rx_ready,
  output logic [$clog2(PAR_MAX_VAL+1)-1:0]     pw_par,
  output logic [$clog2(ADDR_MAX+1)-1:0]        addr,
  output logic                                 en,
  output logic                                 err,
  output logic                                 busy
);

  localparam int PW = $clog2(PAR_MAX_VAL + 1);
  localparam int AW = $clog2(ADDR_MAX + 1);
  localparam int IW = $clog2(ADDR_MAX + 2);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    INIT, IDLE, GET_ADDR, GET_VAL, GET_CHK, WRITE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      a_q, a_d, v_q, v_d;
  logic [PW-1:0]   pw_par_d;
  logic [AW-1:0]   addr_d;
  logic            en_d, err_d, rx_ready_d, busy_d;
  logic            accept, frame_ok;
  logic [7:0]      sum;

  assign accept = rx_valid && rx_ready;
  // Mod-256 checksum; range checks use the full bytes before any narrowing.
  assign sum = a_q + v_q;
  assign frame_ok = (rx_data == sum) &&
                    ({24'd0, a_q} <= ADDR_MAX) &&
                    ({24'd0, v_q} <= PAR_MAX_VAL);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    v_d      = v_q;
    addr_d   = addr;
    pw_par_d = pw_par;
    en_d     = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      INIT: begin
        if (idx_q == IW'(ADDR_MAX + 1)) begin
          state_d = IDLE;
        end else begin
          en_d     = 1'b1;
          addr_d   = AW'(idx_q);
          pw_par_d = PW'(DEF_VAL);
          idx_d    = idx_q + 1'b1;
        end
      end
      IDLE: begin
        cnt_d = '0;
        if (accept && rx_data == SYNC) state_d = GET_ADDR;
      end
      GET_ADDR, GET_VAL, GET_CHK: begin
        if (accept) begin
          cnt_d = '0;
          if (state_q == GET_ADDR) begin
            a_d     = rx_data;
            state_d = GET_VAL;
          end else if (state_q == GET_VAL) begin
            v_d     = rx_data;
            state_d = GET_CHK;
          end else if (frame_ok) begin
            en_d     = 1'b1;
            addr_d   = AW'(a_q);
            pw_par_d = PW'(v_q);
            state_d  = WRITE;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          // An accepted byte on this same edge takes the branch above instead.
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rx_ready_d = (state_d == IDLE) || (state_d == GET_ADDR) ||
                 (state_d == GET_VAL) || (state_d == GET_CHK);
    busy_d     = (state_d == INIT) || (state_d == WRITE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= INIT;
      idx_q    <= '0;
      cnt_q    <= '0;
      a_q      <= '0;
      v_q      <= '0;
      addr     <= '0;
      pw_par   <= '0;
      en       <= 1'b0;
      err      <= 1'b0;
      rx_ready <= 1'b0;
      busy     <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      v_q      <= v_d;
      addr     <= addr_d;
      pw_par   <= pw_par_d;
      en       <= en_d;
      err      <= err_d;
      rx_ready <= rx_ready_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_par_cmd_ctrl.sv
// Self-checking bench for par_cmd_ctrl: directed scenarios plus a randomized
// frame stream scored against a byte-level frame parser model.
module tb_par_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready, en, err, busy;
  logic [7:0] pw_par;
  logic [2:0] addr;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  typedef struct { int a; int v; int t; } wr_t;
  wr_t wr_q[$];

  always #5 clk = ~clk;

  par_cmd_ctrl dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .pw_par(pw_par), .addr(addr), .en(en),
    .err(err), .busy(busy)
  );

  // Bus monitor: logs every write strobe and error pulse just after each edge
  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (en === 1'b1) wr_q.push_back('{a: int'(addr), v: int'(pw_par), t: cyc});
    if (err === 1'b1) err_cnt++;
    if (en === 1'b1 && err === 1'b1) both_cnt++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Presents one byte from a negedge and returns at the negedge after it transfers
  task automatic send_byte(input logic [7:0] b);
    int w = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) begin
      n_vec++; n_miss++;
      $display("[TB] FAIL rx_ready_wait: got rx_ready=%b required 1 within 20 cycles", rx_ready);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (en !== 1'b0) begin n_miss++; $display("[TB] FAIL rst_en: got %b required 0", en); end
    n_vec++; if (err !== 1'b0) begin n_miss++; $display("[TB] FAIL rst_err: got %b required 0", err); end
    n_vec++; if (addr !== 3'd0) begin n_miss++; $display("[TB] FAIL rst_addr: got %0d required 0", addr); end
    n_vec++; if (pw_par !== 8'd0) begin n_miss++; $display("[TB] FAIL rst_pw_par: got %0d required 0", pw_par); end
    n_vec++; if (rx_ready !== 1'b0) begin n_miss++; $display("[TB] FAIL rst_rx_ready: got %b required 0", rx_ready); end
    n_vec++; if (busy !== 1'b1) begin n_miss++; $display("[TB] FAIL rst_busy: got %b required 1", busy); end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_vec++;
      if (en !== 1'b1 || addr !== 3'(k) || pw_par !== 8'd250 || rx_ready !== 1'b0) begin
        n_miss++;
        $display("[TB] FAIL preload[%0d]: got en=%b addr=%0d pw_par=%0d rx_ready=%b required en=1 addr=%0d pw_par=250 rx_ready=0",
                 k, en, addr, pw_par, rx_ready, k);
      end
    end
    @(negedge clk);
    n_vec++;
    if (en !== 1'b0 || rx_ready !== 1'b1 || busy !== 1'b0) begin
      n_miss++;
      $display("[TB] FAIL preload_done: got en=%b rx_ready=%b busy=%b required 0 1 0", en, rx_ready, busy);
    end
  endtask

  task automatic test_valid_frame;
    wr_q.delete();
    err_cnt = 0;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h64); send_byte(8'h66);
    n_vec++;
    if (en !== 1'b1 || addr !== 3'd2 || pw_par !== 8'd100 || rx_ready !== 1'b0) begin
      n_miss++;
      $display("[TB] FAIL valid_write: got en=%b addr=%0d pw_par=%0d rx_ready=%b required 1 2 100 0", en, addr, pw_par, rx_ready);
    end
    @(negedge clk);
    n_vec++;
    if (en !== 1'b0 || rx_ready !== 1'b1) begin
      n_miss++;
      $display("[TB] FAIL valid_after: got en=%b rx_ready=%b required 0 1", en, rx_ready);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (wr_q.size() != 1 || err_cnt != 0) begin
      n_miss++;
      $display("[TB] FAIL valid_count: got writes=%0d errs=%0d required 1 0", wr_q.size(), err_cnt);
    end
  endtask

  task automatic test_bad_checksum;
    wr_q.delete();
    err_cnt = 0;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h64); send_byte(8'h67);
    n_vec++;
    if (err !== 1'b1 || en !== 1'b0 || addr !== 3'd2 || pw_par !== 8'd100) begin
      n_miss++;
      $display("[TB] FAIL bad_chk: got err=%b en=%b addr=%0d pw_par=%0d required 1 0 2 100", err, en, addr, pw_par);
    end
    @(negedge clk);
    n_vec++; if (err !== 1'b0) begin n_miss++; $display("[TB] FAIL bad_chk_pulse: got err=%b required 0", err); end
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h0A); send_byte(8'h0B);
    n_vec++;
    if (en !== 1'b1 || addr !== 3'd1 || pw_par !== 8'd10) begin
      n_miss++;
      $display("[TB] FAIL recover_write: got en=%b addr=%0d pw_par=%0d required 1 1 10", en, addr, pw_par);
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (wr_q.size() != 1 || err_cnt != 1) begin
      n_miss++;
      $display("[TB] FAIL bad_chk_count: got writes=%0d errs=%0d required 1 1", wr_q.size(), err_cnt);
    end
  endtask

  task automatic test_range_and_junk;
    wr_q.delete();
    err_cnt = 0;
    send_byte(8'hA5); send_byte(8'h05); send_byte(8'h10); send_byte(8'h15);
    n_vec++;
    if (err !== 1'b1 || en !== 1'b0) begin
      n_miss++;
      $display("[TB] FAIL addr_range: got err=%b en=%b required 1 0", err, en);
    end
    @(negedge clk);
    err_cnt = 0;
    send_byte(8'h00); send_byte(8'hFF);
    @(negedge clk);
    n_vec++; if (err_cnt != 0) begin n_miss++; $display("[TB] FAIL junk_err: got errs=%0d required 0", err_cnt); end
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'hA5); send_byte(8'hA8);
    n_vec++;
    if (en !== 1'b1 || addr !== 3'd3 || pw_par !== 8'hA5) begin
      n_miss++;
      $display("[TB] FAIL sync_as_data: got en=%b addr=%0d pw_par=%0h required 1 3 a5", en, addr, pw_par);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    err_cnt = 0;
    wr_q.delete();
    send_byte(8'hA5); send_byte(8'h03);
    repeat (999) @(negedge clk);
    n_vec++; if (err_cnt != 0) begin n_miss++; $display("[TB] FAIL timeout_early: got errs=%0d required 0 before cycle 1000", err_cnt); end
    @(negedge clk);
    n_vec++;
    if (err !== 1'b1 || rx_ready !== 1'b1 || busy !== 1'b0) begin
      n_miss++;
      $display("[TB] FAIL timeout_fire: got err=%b rx_ready=%b busy=%b required 1 1 0", err, rx_ready, busy);
    end
    @(negedge clk);
    n_vec++; if (err !== 1'b0) begin n_miss++; $display("[TB] FAIL timeout_pulse: got err=%b required 0", err); end
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01); send_byte(8'h05);
    n_vec++;
    if (en !== 1'b1 || addr !== 3'd4 || pw_par !== 8'd1) begin
      n_miss++;
      $display("[TB] FAIL timeout_idle: got en=%b addr=%0d pw_par=%0d required 1 4 1", en, addr, pw_par);
    end
    @(negedge clk);
    err_cnt = 0;
    send_byte(8'hA5); send_byte(8'h03);
    repeat (999) @(negedge clk);
    send_byte(8'h20);
    n_vec++; if (err_cnt != 0) begin n_miss++; $display("[TB] FAIL timeout_byte_wins: got errs=%0d required 0", err_cnt); end
    send_byte(8'h23);
    n_vec++;
    if (en !== 1'b1 || addr !== 3'd3 || pw_par !== 8'h20) begin
      n_miss++;
      $display("[TB] FAIL timeout_continue: got en=%b addr=%0d pw_par=%0h required 1 3 20", en, addr, pw_par);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int av[3] = '{0, 1, 4};
    int vv[3];
    wr_q.delete();
    for (int f = 0; f < 3; f++) begin
      vv[f] = int'($urandom_range(0, 255));
      send_byte(8'hA5); send_byte(8'(av[f])); send_byte(8'(vv[f])); send_byte(8'((av[f] + vv[f]) % 256));
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (wr_q.size() != 3) begin
      n_miss++;
      $display("[TB] FAIL b2b_count: got %0d writes required 3", wr_q.size());
    end else begin
      for (int f = 0; f < 3; f++) begin
        n_vec++;
        if (wr_q[f].a != av[f] || wr_q[f].v != vv[f]) begin
          n_miss++;
          $display("[TB] FAIL b2b_write[%0d]: got addr=%0d val=%0d required %0d %0d", f, wr_q[f].a, wr_q[f].v, av[f], vv[f]);
        end
        if (f > 0) begin
          n_vec++;
          if (wr_q[f].t - wr_q[f-1].t != 5) begin
            n_miss++;
            $display("[TB] FAIL b2b_spacing[%0d]: got %0d cycles required 5", f, wr_q[f].t - wr_q[f-1].t);
          end
        end
      end
    end
  endtask

  task automatic test_random_frames;
    logic [7:0] stream[$];
    wr_t exp_q[$];
    int exp_err = 0;
    int pos = 0;
    int ma = 0, mv = 0, a, v, c;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 3) == 0) stream.push_back(8'($urandom_range(0, 'hA4)));
      a = int'($urandom_range(0, 7));
      v = int'($urandom_range(0, 255));
      c = (a + v) % 256;
      if ($urandom_range(0, 3) == 0) c = (c + int'($urandom_range(1, 255))) % 256;
      stream.push_back(8'hA5); stream.push_back(8'(a)); stream.push_back(8'(v)); stream.push_back(8'(c));
    end
    // Reference: parse the byte stream into frames and decide each one
    foreach (stream[i]) begin
      if (pos == 0) begin
        if (stream[i] == 8'hA5) pos = 1;
      end else if (pos == 1) begin
        ma = int'(stream[i]); pos = 2;
      end else if (pos == 2) begin
        mv = int'(stream[i]); pos = 3;
      end else begin
        if (int'(stream[i]) == (ma + mv) % 256 && ma <= 4 && mv <= 255) exp_q.push_back('{a: ma, v: mv, t: 0});
        else exp_err++;
        pos = 0;
      end
    end
    wr_q.delete();
    err_cnt = 0;
    both_cnt = 0;
    foreach (stream[i]) begin
      send_byte(stream[i]);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    n_vec++;
    if (err_cnt != exp_err || both_cnt != 0) begin
      n_miss++;
      $display("[TB] FAIL rand_err: got errs=%0d overlap=%0d required %0d 0", err_cnt, both_cnt, exp_err);
    end
    n_vec++;
    if (wr_q.size() != exp_q.size()) begin
      n_miss++;
      $display("[TB] FAIL rand_count: got %0d writes required %0d", wr_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_vec++;
        if (wr_q[i].a != exp_q[i].a || wr_q[i].v != exp_q[i].v) begin
          n_miss++;
          $display("[TB] FAIL rand_write[%0d]: got addr=%0d val=%0d required %0d %0d", i, wr_q[i].a, wr_q[i].v, exp_q[i].a, exp_q[i].v);
        end
      end
    end
  endtask

  task automatic test_mid_frame_reset;
    send_byte(8'hA5); send_byte(8'h03);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (en !== 1'b0 || err !== 1'b0 || addr !== 3'd0 || pw_par !== 8'd0 || rx_ready !== 1'b0 || busy !== 1'b1) begin
      n_miss++;
      $display("[TB] FAIL midrst_values: got en=%b err=%b addr=%0d pw_par=%0d rx_ready=%b busy=%b required 0 0 0 0 0 1",
               en, err, addr, pw_par, rx_ready, busy);
    end
    @(negedge clk);
    wr_q.delete();
    err_cnt = 0;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_vec++;
      if (en !== 1'b1 || addr !== 3'(k) || pw_par !== 8'd250) begin
        n_miss++;
        $display("[TB] FAIL midrst_preload[%0d]: got en=%b addr=%0d pw_par=%0d required 1 %0d 250", k, en, addr, pw_par, k);
      end
    end
    send_byte(8'h30); send_byte(8'h33);
    repeat (5) @(negedge clk);
    n_vec++;
    if (wr_q.size() != 5 || err_cnt != 0) begin
      n_miss++;
      $display("[TB] FAIL midrst_no_write: got writes=%0d errs=%0d required 5 0", wr_q.size(), err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_bad_checksum();
    test_range_and_junk();
    test_timeout();
    test_back_to_back();
    test_random_frames();
    test_mid_frame_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
